seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 240 ++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus iterative shift-add
// multiply and restoring divide/modulo, with registered result and status flags.
module seq_alu #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [3:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic [N-1:0] result_hi,
   output logic         flag_neg,
   output logic         flag_zero,
   output logic         flag_carry,
   output logic         flag_over,
   output logic         flag_err
);

   localparam int unsigned CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   typedef enum logic [3:0] {
      OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_XOR = 4'd4,
      OP_SHL = 4'd5, OP_SHR = 4'd6, OP_MUL = 4'd7, OP_DIV = 4'd8, OP_MOD = 4'd9
   } op_t;

   state_t         state_q, state_d;
   op_t            op_q, op_d;
   op_t            op_in;
   logic [N-1:0]   opnd_q, opnd_d;
   logic [N-1:0]   hi_q, hi_d;
   logic [N-1:0]   lo_q, lo_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   logic [N-1:0]   result_q, result_hi_q;
   logic           neg_q, zero_q, carry_q, over_q, err_q;

   logic           iter_op, last_iter, load;
   logic [N-1:0]   ld_res, ld_hi;
   logic           ld_carry, ld_over, ld_err;

   logic [N:0]     add_w, sub_w;
   logic [N-1:0]   sc_res;
   logic           sc_carry, sc_over, sc_err;

   logic [N:0]     mul_sum, div_sh, div_tr;
   logic [N-1:0]   mul_hi, mul_lo, div_hi, div_lo;
   logic           div_ok;

   assign op_in     = op_t'(op);
   assign iter_op   = (op_in == OP_MUL) || (((op_in == OP_DIV) || (op_in == OP_MOD)) && (b != '0));
   assign last_iter = (state_q == CALC) && (cnt_q == CW'(N - 1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = iter_op ? CALC : DONE;
         CALC:    if (last_iter) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
   end

   // ---------------- single-cycle operations ----------------
   assign add_w = {1'b0, a} + {1'b0, b};
   assign sub_w = {1'b0, a} - {1'b0, b};

   always_comb begin
      sc_res   = '0;
      sc_carry = 1'b0;
      sc_over  = 1'b0;
      sc_err   = 1'b0;
      case (op_in)
         OP_ADD: begin
            sc_res   = add_w[N-1:0];
            sc_carry = add_w[N];
            sc_over  = (a[N-1] == b[N-1]) && (add_w[N-1] != a[N-1]);
         end
         OP_SUB: begin
            sc_res   = sub_w[N-1:0];
            sc_carry = sub_w[N];
            sc_over  = (a[N-1] != b[N-1]) && (sub_w[N-1] != a[N-1]);
         end
         OP_AND: sc_res = a & b;
         OP_OR:  sc_res = a | b;
         OP_XOR: sc_res = a ^ b;
         OP_SHL: begin
            sc_res   = {a[N-2:0], 1'b0};
            sc_carry = a[N-1];
         end
         OP_SHR: begin
            sc_res   = {1'b0, a[N-1:1]};
            sc_carry = a[0];
         end
         OP_MUL: sc_res = '0;
         OP_DIV, OP_MOD: begin
            sc_res = '1;
            sc_err = 1'b1;
         end
         default: sc_err = 1'b1;
      endcase
   end

   // ---------------- iterative step logic ----------------
   // opnd_q holds the multiplicand for MUL and the divisor for DIV/MOD;
   // lo_q holds the multiplier (MUL) or the dividend/quotient shift register.
   assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_hi  = mul_sum[N:1];
   assign mul_lo  = {mul_sum[0], lo_q[N-1:1]};

   assign div_sh  = {hi_q, lo_q[N-1]};
   assign div_tr  = div_sh - {1'b0, opnd_q};
   assign div_ok  = ~div_tr[N];
   assign div_hi  = div_ok ? div_tr[N-1:0] : div_sh[N-1:0];
   assign div_lo  = {lo_q[N-2:0], div_ok};

   always_comb begin
      op_d     = op_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      load     = 1'b0;
      ld_res   = '0;
      ld_hi    = '0;
      ld_carry = 1'b0;
      ld_over  = 1'b0;
      ld_err   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d  = op_in;
               cnt_d = '0;
               hi_d  = '0;
               if (op_in == OP_MUL) begin
                  opnd_d = a;
                  lo_d   = b;
               end else begin
                  opnd_d = b;
                  lo_d   = a;
               end
               if (!iter_op) begin
                  load     = 1'b1;
                  ld_res   = sc_res;
                  ld_carry = sc_carry;
                  ld_over  = sc_over;
                  ld_err   = sc_err;
               end
            end
         end
         CALC: begin
            cnt_d = cnt_q + CW'(1);
            if (op_q == OP_MUL) begin
               hi_d = mul_hi;
               lo_d = mul_lo;
            end else begin
               hi_d = div_hi;
               lo_d = div_lo;
            end
            if (last_iter) begin
               load  = 1'b1;
               cnt_d = '0;
               case (op_q)
                  OP_MUL: begin
                     ld_res  = mul_lo;
                     ld_hi   = mul_hi;
                     ld_over = (mul_hi != '0);
                  end
                  OP_DIV:  ld_res = div_lo;
                  default: ld_res = div_hi;
               endcase
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= OP_ADD;
         opnd_q <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         cnt_q  <= '0;
      end else begin
         op_q   <= op_d;
         opnd_q <= opnd_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         cnt_q  <= cnt_d;
      end
   end

   // Result and flags load only on the edge entering DONE, so they are new in the done cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q    <= '0;
         result_hi_q <= '0;
         neg_q       <= 1'b0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         over_q      <= 1'b0;
         err_q       <= 1'b0;
      end else if (load) begin
         result_q    <= ld_res;
         result_hi_q <= ld_hi;
         neg_q       <= ld_res[N-1];
         zero_q      <= (ld_res == '0);
         carry_q     <= ld_carry;
         over_q      <= ld_over;
         err_q       <= ld_err;
      end
   end

   assign result     = result_q;
   assign result_hi  = result_hi_q;
   assign flag_neg   = neg_q;
   assign flag_zero  = zero_q;
   assign flag_carry = carry_q;
   assign flag_over  = over_q;
   assign flag_err   = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at N=8 and N=4, with a spec-level
// reference model for the operand sweep.
module tb_seq_alu;

   typedef struct {
      logic [7:0] res;
      logic [7:0] hi;
      logic       neg;
      logic       zero;
      logic       carry;
      logic       over;
      logic       err;
      int         lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       sel4;

   logic       start8, busy8, done8;
   logic [3:0] op8;
   logic [7:0] a8, b8, res8, hi8;
   logic       neg8, zero8, carry8, over8, err8;

   logic       start4, busy4, done4;
   logic [3:0] op4;
   logic [3:0] a4, b4, res4, hi4;
   logic       neg4, zero4, carry4, over4, err4;

   logic       done_m, busy_m;
   logic [7:0] res_m, hi_m;
   logic [4:0] flags_m;

   int nassert = 0;
   int nfail   = 0;

   always #5 clk = ~clk;

   seq_alu #(.N(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .result(res8), .result_hi(hi8),
      .flag_neg(neg8), .flag_zero(zero8), .flag_carry(carry8),
      .flag_over(over8), .flag_err(err8)
   );

   seq_alu #(.N(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .op(op4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .result(res4), .result_hi(hi4),
      .flag_neg(neg4), .flag_zero(zero4), .flag_carry(carry4),
      .flag_over(over4), .flag_err(err4)
   );

   assign done_m  = sel4 ? done4 : done8;
   assign busy_m  = sel4 ? busy4 : busy8;
   assign res_m   = sel4 ? {4'b0, res4} : res8;
   assign hi_m    = sel4 ? {4'b0, hi4}  : hi8;
   assign flags_m = sel4 ? {neg4, zero4, carry4, over4, err4}
                         : {neg8, zero8, carry8, over8, err8};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nassert++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] r, input logic [7:0] h, input logic n,
                               input logic z, input logic c, input logic o, input logic e,
                               input int l);
      exp_t x;
      x.res = r; x.hi = h; x.neg = n; x.zero = z; x.carry = c; x.over = o; x.err = e; x.lat = l;
      return x;
   endfunction

   // Reference behaviour written directly from the operation definitions.
   function automatic exp_t model(input int unsigned w, input logic [3:0] o,
                                  input int unsigned av, input int unsigned bv);
      exp_t        x;
      int unsigned m = (1 << w) - 1;
      int unsigned r = 0;
      int unsigned h = 0;
      int unsigned s;
      bit          ma, mb;
      ma = ((av >> (w - 1)) & 1) != 0;
      mb = ((bv >> (w - 1)) & 1) != 0;
      x.carry = 1'b0; x.over = 1'b0; x.err = 1'b0; x.lat = 1;
      case (o)
         4'd0: begin
            s = av + bv; r = s & m;
            x.carry = ((s >> w) & 1) != 0;
            x.over  = (ma == mb) && ((((r >> (w - 1)) & 1) != 0) != ma);
         end
         4'd1: begin
            r = (av - bv) & m;
            x.carry = av < bv;
            x.over  = (ma != mb) && ((((r >> (w - 1)) & 1) != 0) != ma);
         end
         4'd2: r = av & bv;
         4'd3: r = av | bv;
         4'd4: r = av ^ bv;
         4'd5: begin r = (av << 1) & m; x.carry = ma; end
         4'd6: begin r = av >> 1; x.carry = (av & 1) != 0; end
         4'd7: begin
            s = av * bv; r = s & m; h = s >> w;
            x.over = h != 0; x.lat = int'(w) + 1;
         end
         4'd8, 4'd9: begin
            if (bv == 0) begin
               r = m; x.err = 1'b1;
            end else begin
               r = (o == 4'd8) ? av / bv : av % bv;
               x.lat = int'(w) + 1;
            end
         end
         default: begin r = 0; x.err = 1'b1; end
      endcase
      x.res  = 8'(r);
      x.hi   = 8'(h);
      x.neg  = ((r >> (w - 1)) & 1) != 0;
      x.zero = (r == 0);
      return x;
   endfunction

   task automatic run(input bit w4, input logic [3:0] o, input logic [7:0] av,
                      input logic [7:0] bv, input exp_t e, input string tag);
      int lat, bcnt;
      sel4 = w4;
      if (w4) begin start4 = 1'b1; op4 = o; a4 = av[3:0]; b4 = bv[3:0]; end
      else    begin start8 = 1'b1; op8 = o; a8 = av;      b8 = bv;      end
      @(posedge clk); #1;
      start4 = 1'b0; start8 = 1'b0;
      op4 = ~op4; op8 = ~op8; a4 = ~a4; b4 = ~b4; a8 = ~a8; b8 = ~b8;
      lat = 1; bcnt = 0;
      while (!done_m && lat < 40) begin
         if (busy_m) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      if (busy_m) bcnt++;
      chk({tag, ".latency"}, lat, e.lat);
      chk({tag, ".busycyc"}, bcnt, e.lat);
      chk({tag, ".result"}, res_m, e.res);
      chk({tag, ".result_hi"}, hi_m, e.hi);
      chk({tag, ".flags(n,z,c,o,e)"}, flags_m, {e.neg, e.zero, e.carry, e.over, e.err});
      @(posedge clk); #1;
      chk({tag, ".idle_after"}, {busy_m, done_m}, 2'b00);
      chk({tag, ".hold"}, res_m, e.res);
   endtask

   initial begin
      bit seen;
      int unsigned av, bv;
      rst = 1'b1; sel4 = 1'b0;
      start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
      start4 = 1'b0; op4 = '0; a4 = '0; b4 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.busy_done8", {busy8, done8}, 2'b00);
      chk("reset.result8", {hi8, res8}, 16'h0000);
      chk("reset.flags8", {neg8, zero8, carry8, over8, err8}, 5'b0);
      chk("reset.dut4", {busy4, done4, hi4, res4, neg4, zero4, carry4, over4, err4}, 15'h0);

      // First start coincides with the first edge that has rst low.
      rst = 1'b0;
      run(0, 4'h0, 8'hFF, 8'h01, mk(8'h00, 8'h00, 0, 1, 1, 0, 0, 1), "add_ff_01");
      run(0, 4'h0, 8'h7F, 8'h01, mk(8'h80, 8'h00, 1, 0, 0, 1, 0, 1), "add_7f_01");
      run(0, 4'h1, 8'h80, 8'h01, mk(8'h7F, 8'h00, 0, 0, 0, 1, 0, 1), "sub_80_01");
      run(0, 4'h1, 8'h03, 8'h05, mk(8'hFE, 8'h00, 1, 0, 1, 0, 0, 1), "sub_03_05");
      run(0, 4'h2, 8'hF0, 8'h3C, mk(8'h30, 8'h00, 0, 0, 0, 0, 0, 1), "and");
      run(0, 4'h3, 8'hF0, 8'h3C, mk(8'hFC, 8'h00, 1, 0, 0, 0, 0, 1), "or");
      run(0, 4'h4, 8'hF0, 8'h3C, mk(8'hCC, 8'h00, 1, 0, 0, 0, 0, 1), "xor");
      run(0, 4'h5, 8'h81, 8'h00, mk(8'h02, 8'h00, 0, 0, 1, 0, 0, 1), "shl_81");
      run(0, 4'h6, 8'h81, 8'h00, mk(8'h40, 8'h00, 0, 0, 1, 0, 0, 1), "shr_81");
      run(0, 4'h7, 8'h10, 8'h0F, mk(8'hF0, 8'h00, 1, 0, 0, 0, 0, 9), "mul_10_0f");
      run(0, 4'h8, 8'd200, 8'd7, mk(8'd28, 8'h00, 0, 0, 0, 0, 0, 9), "div_200_7");
      run(0, 4'h9, 8'd200, 8'd7, mk(8'd4, 8'h00, 0, 0, 0, 0, 0, 9), "mod_200_7");
      run(0, 4'h8, 8'd5, 8'd0, mk(8'hFF, 8'h00, 1, 0, 0, 0, 1, 1), "div_by_zero");
      run(0, 4'h9, 8'd9, 8'd0, mk(8'hFF, 8'h00, 1, 0, 0, 0, 1, 1), "mod_by_zero");
      run(0, 4'hF, 8'h12, 8'h34, mk(8'h00, 8'h00, 0, 1, 0, 0, 1, 1), "illegal_f");
      run(0, 4'hA, 8'h12, 8'h34, mk(8'h00, 8'h00, 0, 1, 0, 0, 1, 1), "illegal_a");
      run(1, 4'h0, 8'h0F, 8'h01, mk(8'h00, 8'h00, 0, 1, 1, 0, 0, 1), "n4_add_f_1");
      run(1, 4'h7, 8'h0F, 8'h0F, mk(8'h01, 8'h0E, 0, 0, 0, 1, 0, 5), "n4_mul_f_f");
      run(1, 4'h8, 8'h0D, 8'h03, mk(8'h04, 8'h00, 0, 0, 0, 0, 0, 5), "n4_div_13_3");
      run(0, 4'h7, 8'hFF, 8'hFF, mk(8'h01, 8'hFE, 0, 0, 0, 1, 0, 9), "mul_ff_ff");

      // Abort: MUL in flight, extra start during CALC, then reset (with start) mid-iteration.
      sel4 = 1'b0;
      start8 = 1'b1; op8 = 4'h7; a8 = 8'h03; b8 = 8'h05;
      @(posedge clk); #1;
      op8 = 4'h0; a8 = 8'h11; b8 = 8'h22;
      @(posedge clk); #1;
      start8 = 1'b0;
      chk("abort.busy_in_calc", {busy8, done8}, 2'b10);
      repeat (2) @(posedge clk);
      #1;
      chk("abort.no_done_yet", {busy8, done8}, 2'b10);
      rst = 1'b1; start8 = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start8 = 1'b0;
      chk("abort.busy_done", {busy8, done8}, 2'b00);
      chk("abort.result", {hi8, res8}, 16'h0000);
      chk("abort.flags", {neg8, zero8, carry8, over8, err8}, 5'b0);
      seen = 1'b0;
      for (int unsigned i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         seen = seen | done8 | busy8;
      end
      chk("abort.stays_idle", seen, 1'b0);
      run(0, 4'h0, 8'h21, 8'h12, mk(8'h33, 8'h00, 0, 0, 0, 0, 0, 1), "after_abort_add");

      // Operand sweep over all legal ops at both widths against the model.
      for (int unsigned w = 0; w < 2; w++) begin
         for (int unsigned o = 0; o < 10; o++) begin
            for (int unsigned k = 0; k < 3; k++) begin
               av = $urandom_range((w == 1) ? 15 : 255, 0);
               bv = $urandom_range((w == 1) ? 15 : 255, 0);
               run(w == 1, 4'(o), 8'(av), 8'(bv), model((w == 1) ? 4 : 8, 4'(o), av, bv), "sweep");
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end

endmodule
